// File: rtl/rf_mp.sv
// Multi-ported register file with dual write ports, write-to-read bypass,
// a post-reset clear sweep and a per-register pending scoreboard.
module rf_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_pend,
    input  logic                    we0,
    input  logic [AW-1:0]           wa0,
    input  logic [WIDTH-1:0]        wd0,
    input  logic                    we1,
    input  logic [AW-1:0]           wa1,
    input  logic [WIDTH-1:0]        wd1,
    input  logic                    alloc_en,
    input  logic [AW-1:0]           alloc_addr,
    output logic                    ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]       state;
    logic [AW:0]      idx;
    logic [AW:0]      idx_nxt;
    logic             run;
    logic             w0_ok;
    logic             w1_ok;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;

    assign run     = (state == ST_RUN);
    assign ready   = run;
    assign idx_nxt = idx + 1'b1;

    // Sweep ends when the index carries into bit AW, i.e. after entry DEPTH-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end else if (!run) begin
            idx <= idx_nxt;
            if (idx_nxt[AW]) begin
                state <= ST_RUN;
            end
        end
    end

    assign w0_ok = run && we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign w1_ok = run && we1 && !((ZERO_REG != 0) && (wa1 == '0));

    // Port 1 is assigned last so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[idx[AW-1:0]] <= '0;
        end else begin
            if (w0_ok) begin
                mem[wa0] <= wd0;
            end
            if (w1_ok) begin
                mem[wa1] <= wd1;
            end
        end
    end

    // Allocation is applied after the clears: a new producer supersedes the old one.
    always_comb begin
        pend_nxt = pend;
        if (we0) begin
            pend_nxt[wa0] = 1'b0;
        end
        if (we1) begin
            pend_nxt[wa1] = 1'b0;
        end
        if (alloc_en) begin
            pend_nxt[alloc_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (run) begin
            pend <= pend_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    a;
        logic             hit0;
        logic             hit1;
        logic             is_zero;
        logic [WIDTH-1:0] d;

        assign a       = rd_addr[i*AW +: AW];
        assign hit1    = we1 && (wa1 == a);
        assign hit0    = we0 && (wa0 == a);
        assign is_zero = (ZERO_REG != 0) && (a == '0);

        always_comb begin
            if (!run || !rd_en[i] || is_zero) begin
                d = '0;
            end else if (hit1) begin
                d = wd1;
            end else if (hit0) begin
                d = wd0;
            end else begin
                d = mem[a];
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = d;
        // A same-cycle writeback releases the consumer immediately.
        assign rd_pend[i] = run && rd_en[i] && pend[a] && !hit1 && !hit0;
    end

endmodule

// File: doc/rf_mp.md
Name: rf_mp

Overview:
Parametrised multi-ported register file for the RISC-V main processor. It provides configurable width, depth and read-port count, and two write ports with write-to-read bypass. It adds a post-reset hardware clear sweep and a per-register pending scoreboard so the decode stage can stall on outstanding producers. It sits between decode (reads, allocation) and writeback (writes).

Parameters:
WIDTH, 32, data bits per register
DEPTH, 32, number of registers (power of two, >=4)
AW, 5, address width, equals log2(DEPTH)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, when 1 register 0 always reads zero, is never written and never pends

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*AW  packed read addresses; port i at [i*AW +: AW]
rd_data  out  NUM_RD*WIDTH  packed read data, combinational
rd_pend  out  NUM_RD  per-port pending flag, combinational
we0  in  1  write port 0 enable
wa0  in  AW  write port 0 address
wd0  in  WIDTH  write port 0 data
we1  in  1  write port 1 enable; port 1 has priority over port 0
wa1  in  AW  write port 1 address
wd1  in  WIDTH  write port 1 data
alloc_en  in  1  mark a register as pending (a producer is in flight)
alloc_addr  in  AW  register to mark
ready  out  1  high when the clear sweep is done and the file is usable

Behaviour:
- Reset (rst_n low at posedge):
  - FSM goes to CLEAR, sweep index goes to 0, all pending bits clear, ready goes 0.
  - Reset asserted mid-sweep restarts the sweep at index 0.
- FSM states:
  - CLEAR: writes 0 to entry[idx] each cycle, then idx+1. After entry DEPTH-1 is written, the next state is RUN. A full sweep takes exactly DEPTH cycles after rst_n rises. ready is 1 only in RUN.
  - RUN: normal operation. The FSM never leaves RUN except by reset.
- During CLEAR:
  - we0, we1 and alloc_en are ignored.
  - All rd_data are 0 and all rd_pend are 0.
- Writes (RUN, posedge):
  - we0 writes wd0 to entry[wa0]; we1 writes wd1 to entry[wa1].
  - Same address on both ports: wd1 is stored.
  - Writes to address 0 are dropped when ZERO_REG=1.
- Reads (combinational, port i), evaluated in priority order:
  1. rd_en[i]=0: data 0.
  2. Address 0 with ZERO_REG=1: data 0.
  3. we1 and wa1 matches: data is wd1.
  4. we0 and wa0 matches: data is wd0.
  5. Otherwise: data is the stored entry.
  - Read-after-write in the same cycle therefore returns the new value, with port 1 bypass beating port 0.
- Scoreboard (RUN, posedge):
  - pend[alloc_addr] is set by alloc_en.
  - pend[wa0] is cleared by we0; pend[wa1] is cleared by we1.
  - Set and clear to the same address in the same cycle: set wins (a new producer supersedes the old one).
  - Address 0 never pends when ZERO_REG=1.
- rd_pend[i]:
  - Equals rd_en[i] & pend[addr_i] & ~(bypass write to addr_i this cycle).
  - So a consumer sees "not pending" in the same cycle the producer writes back.
- Width rules:
  - No truncation: wd* and rd_data are exactly WIDTH bits.
  - Addresses are AW bits, so the sweep index is AW+1 bits to detect the terminal count.
- Entry contents are defined only after the sweep; no X is ever driven on rd_data in RUN.

Test Plan:
- Reset sweep: hold rst_n=0 for 2 cycles, then release. Require ready=0 for exactly 32 cycles, then 1. Reading every address with rd_en=1 then returns 0x00000000.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 10 for one cycle. Require ready to rise 32 cycles after the re-release, not earlier. Require writes issued during the sweep (we0=1, wa0=3, wd0=0x55) to be lost: x3 reads 0.
- Write/bypass and dual-port priority:
  - we0=1, wa0=5, wd0=0xDEADBEEF with rd_addr0=5 in the same cycle: rd_data0=0xDEADBEEF combinationally; x5 holds the value next cycle.
  - Then we0=1 and we1=1 both to wa=7 with wd0=0x1111 and wd1=0x2222: bypass gives 0x2222 and x7 stores 0x2222.
- Zero register: we1=1, wa1=0, wd1=0xFFFFFFFF; alloc_en=1, alloc_addr=0. Require rd_data=0 and rd_pend=0 for address 0, both in that cycle and after.
- Scoreboard:
  - alloc x9 in cycle n: rd_pend for x9 is 1 from n+1.
  - we0 to x9 in cycle m: rd_pend is 0 in cycle m (bypass) and stays 0 after.
  - Simultaneous alloc_en x9 and we0 x9: pend is still 1 next cycle.
- Parametrisation: instantiate WIDTH=64, DEPTH=16, NUM_RD=3. Require a 16-cycle sweep. All three ports read x15=0x0123456789ABCDEF after a write. Port 2 with rd_en=0 reads 0.
